frame_geometry: RTL and testbench

//  Measures incoming image geometry: pixels per line (Width) and lines per frame (Height).

---
 rtl/frame_geometry_if.sv | 25 ++
 rtl/frame_geometry.sv | 136 +++++++++++++
 tb/tb_frame_geometry.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_geometry_if.sv
// Strobe/measurement bundle between a video source (master) and frame_geometry (slave).
interface frame_geometry_if #(
  parameter int CNT_W = 8
);
  logic             Enable;
  logic             Pixel;
  logic             Line;
  logic             Frame;
  logic [CNT_W-1:0] Width;
  logic [CNT_W-1:0] Height;
  logic             Valid;
  logic             Locked;
  logic             LineErr;
  logic             Ovf;

  modport master (
    output Enable, Pixel, Line, Frame,
    input  Width, Height, Valid, Locked, LineErr, Ovf
  );

  modport slave (
    input  Enable, Pixel, Line, Frame,
    output Width, Height, Valid, Locked, LineErr, Ovf
  );
endinterface

// File: rtl/frame_geometry.sv
// Measures pixels/line and lines/frame, flags inconsistent lines, and locks once
// the same good geometry has been seen LOCK_FRAMES frames in a row.
//
// state   | meaning
// SYNC    | discarding the partial frame seen after reset/Enable; waits for EOF
// MEASURE | publishing good frames, counting consecutive identical ones
// LOCKED  | geometry stable; any bad or different frame drops back to MEASURE
module frame_geometry #(
  parameter int CNT_W       = 8,
  parameter int LOCK_FRAMES = 2
) (
  input logic            Clk,
  input logic            nReset,
  frame_geometry_if.slave bus
);
  localparam int               MW     = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] MAX    = '1;
  localparam logic [MW-1:0]    LOCK_N = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SYNC = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  state_t           state, state_nx;
  logic [MW-1:0]    match_cnt, match_nx;
  logic [CNT_W-1:0] pix_cnt, line_cnt, ref_len, width_q, height_q;
  logic             bad, valid_q, ovf_q, line_err_q;
  logic             eol, eof, pix_sat, line_sat, first_line, mismatch, frame_bad, same, publish;
  logic [CNT_W-1:0] len, lines, ref_eff;

  assign eol        = bus.Enable & bus.Pixel & bus.Line;
  assign eof        = eol & bus.Frame;
  assign pix_sat    = bus.Enable & bus.Pixel & (pix_cnt == MAX);
  assign line_sat   = eol & (line_cnt == MAX);
  assign len        = pix_sat ? MAX : pix_cnt + 1'b1;
  assign lines      = line_sat ? MAX : line_cnt + 1'b1;
  assign first_line = (line_cnt == '0);
  assign mismatch   = eol & ~first_line & (len != ref_len);
  // a single-line frame loads its reference in the EOF cycle itself
  assign ref_eff    = first_line ? len : ref_len;
  assign frame_bad  = bad | pix_sat | line_sat | mismatch;
  assign same       = valid_q & (ref_eff == width_q) & (lines == height_q);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= SYNC;
      match_cnt <= '0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
    end
  end

  always_comb begin
    state_nx = state;
    match_nx = match_cnt;
    publish  = 1'b0;
    if (!bus.Enable) begin
      state_nx = SYNC;
      match_nx = '0;
    end else if (eof) begin
      unique case (state)
        SYNC: begin
          state_nx = MEASURE;
          match_nx = '0;
        end
        MEASURE: begin
          if (frame_bad) begin
            match_nx = '0;
          end else begin
            publish  = 1'b1;
            match_nx = same ? match_cnt + 1'b1 : MW'(1);
            if (match_nx >= LOCK_N) state_nx = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_bad) begin
            state_nx = MEASURE;
            match_nx = '0;
          end else if (!same) begin
            state_nx = MEASURE;
            publish  = 1'b1;
            match_nx = MW'(1);
          end
        end
        default: begin
          state_nx = SYNC;
          match_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      ref_len    <= '0;
      bad        <= 1'b0;
      ovf_q      <= 1'b0;
      line_err_q <= 1'b0;
      valid_q    <= 1'b0;
      width_q    <= '0;
      height_q   <= '0;
    end else if (!bus.Enable) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      ref_len    <= '0;
      bad        <= 1'b0;
      ovf_q      <= 1'b0;
      line_err_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      if (eol)                  pix_cnt <= '0;
      else if (bus.Pixel && !pix_sat) pix_cnt <= pix_cnt + 1'b1;
      if (eof)                  line_cnt <= '0;
      else if (eol && !line_sat) line_cnt <= line_cnt + 1'b1;
      if (eol && first_line) ref_len <= len;
      if (eof)                                  bad <= 1'b0;
      else if (pix_sat || line_sat || mismatch) bad <= 1'b1;
      if (pix_sat || line_sat) ovf_q <= 1'b1;
      // partial lines seen while syncing are expected to disagree; stay quiet
      line_err_q <= mismatch && (state != SYNC);
      if (publish) begin
        width_q  <= ref_eff;
        height_q <= lines;
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.Width   = width_q;
  assign bus.Height  = height_q;
  assign bus.Valid   = valid_q;
  assign bus.Locked  = (state == LOCKED);
  assign bus.LineErr = line_err_q;
  assign bus.Ovf     = ovf_q;
endmodule

// File: tb/tb_frame_geometry.sv
// Scoreboard bench for frame_geometry: an 8-bit instance for geometry/lock behaviour
// and a 4-bit instance for counter saturation.
module tb_frame_geometry;
  typedef struct {
    bit    sel;
    int    w;
    int    h;
    bit    v;
    bit    l;
    bit    o;
    string nm;
  } exp_t;

  logic Clk;
  logic nReset;
  bit   tgt;
  int   n_pass;
  int   n_total;

  exp_t frm_q[$];
  exp_t snap_q[$];
  bit   lerr_q[$];

  frame_geometry_if #(.CNT_W(8)) if8 ();
  frame_geometry_if #(.CNT_W(4)) if4 ();

  frame_geometry #(.CNT_W(8), .LOCK_FRAMES(2)) u8 (.Clk(Clk), .nReset(nReset), .bus(if8.slave));
  frame_geometry #(.CNT_W(4), .LOCK_FRAMES(2)) u4 (.Clk(Clk), .nReset(nReset), .bus(if4.slave));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endfunction

  function automatic void cmp(input exp_t e);
    if (e.sel) begin
      chk({e.nm, "_width"},  int'(if4.Width),  e.w);
      chk({e.nm, "_height"}, int'(if4.Height), e.h);
      chk({e.nm, "_valid"},  int'(if4.Valid),  int'(e.v));
      chk({e.nm, "_locked"}, int'(if4.Locked), int'(e.l));
      chk({e.nm, "_ovf"},    int'(if4.Ovf),    int'(e.o));
    end else begin
      chk({e.nm, "_width"},  int'(if8.Width),  e.w);
      chk({e.nm, "_height"}, int'(if8.Height), e.h);
      chk({e.nm, "_valid"},  int'(if8.Valid),  int'(e.v));
      chk({e.nm, "_locked"}, int'(if8.Locked), int'(e.l));
      chk({e.nm, "_ovf"},    int'(if8.Ovf),    int'(e.o));
    end
  endfunction

  // monitor: every EOL/EOF the 8-bit DUT accepts triggers a pop and compare
  initial begin
    bit   s_eol, s_eof, b;
    exp_t e;
    forever begin
      @(posedge Clk);
      s_eol = nReset && if8.Enable && if8.Pixel && if8.Line;
      s_eof = s_eol && if8.Frame;
      @(negedge Clk);
      if (s_eol) begin
        if (lerr_q.size() > 0) begin
          b = lerr_q.pop_front();
          chk("line_err", int'(if8.LineErr), int'(b));
        end else chk("line_err_queue", lerr_q.size(), 1);
      end else chk("line_err_idle", int'(if8.LineErr), 0);
      if (s_eof) begin
        if (frm_q.size() > 0) begin
          e = frm_q.pop_front();
          cmp(e);
        end else chk("frame_queue", frm_q.size(), 1);
      end
      if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        cmp(e);
      end
    end
  end

  task automatic drive(input bit p, input bit l, input bit f);
    if8.Pixel = p && !tgt;
    if8.Line  = l && !tgt;
    if8.Frame = f && !tgt;
    if4.Pixel = p && tgt;
    if4.Line  = l && tgt;
    if4.Frame = f && tgt;
    @(posedge Clk);
    #1;
  endtask

  task automatic snap(input bit sel, input int w, input int h, input bit v, input bit l,
                      input bit o, input string nm);
    exp_t e;
    e = '{sel, w, h, v, l, o, nm};
    snap_q.push_back(e);
  endtask

  // fpix: index of a pixel that carries Frame without Line (-1 for none)
  task automatic send_line(input int n, input bit last, input bit lerr, input int fpix);
    for (int i = 0; i < n - 1; i++) drive(1'b1, 1'b0, i == fpix);
    if (!tgt) lerr_q.push_back(lerr);
    drive(1'b1, 1'b1, last);
  endtask

  task automatic send_frame(input int w, input int h, input int odd_line, input int odd_len,
                            input int err_line, input int ew, input int eh, input bit ev,
                            input bit el, input string nm);
    exp_t e;
    e = '{1'b0, ew, eh, ev, el, 1'b0, nm};
    if (!tgt) frm_q.push_back(e);
    for (int li = 0; li < h; li++) begin
      send_line((li == odd_line) ? odd_len : w, li == h - 1, li == err_line, -1);
      drive(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    tgt     = 1'b0;
    nReset  = 1'b0;
    if8.Enable = 1'b1;
    if4.Enable = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    snap(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "reset8");
    snap(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, "reset4");
    drive(1'b0, 1'b0, 1'b0);
    nReset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // first frame is only for sync, then publish, then lock
    send_frame(6, 4, -1, 0, -1, 0, 0, 1'b0, 1'b0, "sync_frame");
    send_frame(6, 4, -1, 0, -1, 6, 4, 1'b1, 1'b0, "first_6x4");
    send_frame(6, 4, -1, 0, -1, 6, 4, 1'b1, 1'b1, "lock_6x4");

    // short third line breaks lock without touching the published geometry
    send_frame(6, 4, 2, 5, 2, 6, 4, 1'b1, 1'b0, "short_line");
    send_frame(6, 4, -1, 0, -1, 6, 4, 1'b1, 1'b0, "relock_a");
    send_frame(6, 4, -1, 0, -1, 6, 4, 1'b1, 1'b1, "relock_b");

    // new good geometry republishes and relocks
    send_frame(8, 3, -1, 0, -1, 8, 3, 1'b1, 1'b0, "new_8x3");
    send_frame(8, 3, -1, 0, -1, 8, 3, 1'b1, 1'b1, "lock_8x3");

    // stray Line/Frame without Pixel, and Frame without Line, change nothing
    begin
      exp_t e;
      e = '{1'b0, 8, 3, 1'b1, 1'b1, 1'b0, "ignored_strobes"};
      frm_q.push_back(e);
    end
    send_line(8, 1'b0, 1'b0, -1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    send_line(8, 1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 1'b1);
    send_line(8, 1'b1, 1'b0, -1);
    drive(1'b0, 1'b0, 1'b0);

    // single-pixel, single-line frames
    send_frame(1, 1, -1, 0, -1, 1, 1, 1'b1, 1'b0, "one_by_one_a");
    send_frame(1, 1, -1, 0, -1, 1, 1, 1'b1, 1'b1, "one_by_one_b");

    // async reset in the middle of a frame
    send_line(6, 1'b0, 1'b0, -1);
    send_line(6, 1'b0, 1'b0, -1);
    nReset = 1'b0;
    snap(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "mid_reset8");
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    nReset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    send_frame(6, 4, -1, 0, -1, 0, 0, 1'b0, 1'b0, "post_reset_sync");
    send_frame(6, 4, -1, 0, -1, 6, 4, 1'b1, 1'b0, "post_reset_pub");

    // mismatch on the EOF line itself makes the frame bad and resets the match count
    send_frame(6, 4, 3, 5, 3, 6, 4, 1'b1, 1'b0, "bad_eof_line");
    send_frame(6, 4, -1, 0, -1, 6, 4, 1'b1, 1'b0, "after_bad_a");
    send_frame(6, 4, -1, 0, -1, 6, 4, 1'b1, 1'b1, "after_bad_b");

    // 4-bit instance: saturation, stickiness, Enable clear
    tgt = 1'b1;
    send_frame(3, 2, -1, 0, -1, 0, 0, 1'b0, 1'b0, "");
    send_line(20, 1'b1, 1'b0, -1);
    drive(1'b0, 1'b0, 1'b0);
    snap(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, "ovf_set");
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    snap(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, "ovf_sticky");
    drive(1'b0, 1'b0, 1'b0);
    if4.Enable = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    if4.Enable = 1'b1;
    snap(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, "ovf_cleared");
    drive(1'b0, 1'b0, 1'b0);
    send_frame(5, 3, -1, 0, -1, 0, 0, 1'b0, 1'b0, "");
    send_frame(5, 3, -1, 0, -1, 0, 0, 1'b0, 1'b0, "");
    snap(1'b1, 5, 3, 1'b1, 1'b0, 1'b0, "w4_publish");
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tgt = 1'b0;

    chk("frame_queue_drained", frm_q.size(), 0);
    chk("lerr_queue_drained", lerr_q.size(), 0);
    chk("snap_queue_drained", snap_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
